// File: rtl/pipe_spawner.sv
`default_nettype none
// ============================================================================
// Module   : pipe_spawner
// Summary  : Three-slot obstacle (pipe) scheduler for a side-scrolling game.
//            Moves active pipes left by SPEED on every frame tick, retires
//            them at the left edge, spawns new pipes every SPAWN_INTERVAL
//            ticks with an LFSR-driven gap centre, and counts pipes passing
//            the bird x-coordinate.
// Options  : PIPE_SCORE_EN - when defined, enables scoring (o_Score_Pulse,
//            o_Score); when undefined both outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_spawner #(
   parameter int SCREEN_W       = 640,
   parameter int SPAWN_INTERVAL = 90,
   parameter int SPEED          = 2,
   parameter int GAP_MIN        = 80,
   parameter int GAP_STEP       = 8,
   parameter int BIRD_X         = 160
) (
   input  logic        i_Clk,
   input  logic        i_Reset_n,
   input  logic        i_Frame_Tick,
   input  logic        i_Start,
   input  logic        i_Game_Over,
   input  logic [4:0]  i_LFSR_Data,
   output logic [2:0]  o_Pipe_Valid,
   output logic [29:0] o_Pipe_X,
   output logic [26:0] o_Gap_Y,
   output logic        o_Spawn,
   output logic        o_Score_Pulse,
   output logic [7:0]  o_Score,
   output logic [1:0]  o_State
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_FROZEN = 2'd2;

   localparam int NUM_SLOTS = 3;

   localparam logic [9:0]  C_SCREEN_W   = 10'(SCREEN_W);
   localparam logic [9:0]  C_SPEED      = 10'(SPEED);
   localparam logic [8:0]  C_GAP_MIN    = 9'(GAP_MIN);
   localparam logic [8:0]  C_GAP_STEP   = 9'(GAP_STEP);
   localparam logic [15:0] C_CNT_RELOAD = 16'(SPAWN_INTERVAL - 1);
`ifdef PIPE_SCORE_EN
   localparam logic [9:0]  C_BIRD_X     = 10'(BIRD_X);
`endif

   logic [1:0]  state_q, state_d;
   logic [2:0]  valid_q, valid_d;
   logic [9:0]  x_q   [NUM_SLOTS];
   logic [9:0]  x_d   [NUM_SLOTS];
   logic [8:0]  gap_q [NUM_SLOTS];
   logic [8:0]  gap_d [NUM_SLOTS];
   logic [15:0] cnt_q, cnt_d;
   logic        spawn_q, spawn_d;
   logic        score_pulse_q, score_pulse_d;
   logic [7:0]  score_q, score_d;

   // Gap centre for a newly spawned pipe, sampled in the tick cycle (9-bit wrap)
   logic [8:0]  gap_new;
   assign gap_new = C_GAP_MIN + 9'(i_LFSR_Data) * C_GAP_STEP;

   logic        free_found;
   logic [1:0]  free_slot;
`ifdef PIPE_SCORE_EN
   logic [1:0]  n_cross;
   logic [8:0]  score_sum;
`endif

   // Next-state logic: start/restart, freeze, and per-tick slot movement/spawning
   always_comb begin
      state_d       = state_q;
      valid_d       = valid_q;
      x_d           = x_q;
      gap_d         = gap_q;
      cnt_d         = cnt_q;
      spawn_d       = 1'b0;
      score_pulse_d = 1'b0;
      score_d       = score_q;
      free_found    = 1'b0;
      free_slot     = 2'd0;
`ifdef PIPE_SCORE_EN
      n_cross       = 2'd0;
      score_sum     = 9'd0;
`endif

      if (i_Start) begin
         // Start from any state (including restart from RUN) begins a fresh game
         state_d = ST_RUN;
         valid_d = 3'b000;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            x_d[k]   = 10'd0;
            gap_d[k] = 9'd0;
         end
         cnt_d   = C_CNT_RELOAD;
         score_d = 8'd0;
      end else if (state_q == ST_RUN) begin
         if (i_Game_Over) begin
            // Freeze has priority over a coincident frame tick
            state_d = ST_FROZEN;
         end else if (i_Frame_Tick) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
               if (valid_q[k]) begin
                  if (x_q[k] >= C_SPEED) begin
                     x_d[k] = x_q[k] - C_SPEED;
`ifdef PIPE_SCORE_EN
                     if ((x_q[k] >= C_BIRD_X) && (x_d[k] < C_BIRD_X)) begin
                        n_cross = n_cross + 2'd1;
                     end
`endif
                  end else begin
                     // Off the left edge: retire, keep last x/gap for debug visibility
                     valid_d[k] = 1'b0;
                  end
               end
            end

            // Spawn target uses validity at the start of the tick, so a slot
            // retired on this tick is not reused until a later one
            for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
               if (!valid_q[k]) begin
                  free_found = 1'b1;
                  free_slot  = 2'(k);
               end
            end

            if (cnt_q == 16'd0) begin
               cnt_d = C_CNT_RELOAD;
               if (free_found) begin
                  valid_d[free_slot] = 1'b1;
                  x_d[free_slot]     = C_SCREEN_W;
                  gap_d[free_slot]   = gap_new;
                  spawn_d            = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end

`ifdef PIPE_SCORE_EN
            score_sum     = {1'b0, score_q} + {7'd0, n_cross};
            score_d       = (score_sum > 9'd255) ? 8'd255 : score_sum[7:0];
            score_pulse_d = (n_cross != 2'd0);
`endif
         end
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q       <= ST_IDLE;
         valid_q       <= 3'b000;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            x_q[k]   <= 10'd0;
            gap_q[k] <= 9'd0;
         end
         cnt_q         <= C_CNT_RELOAD;
         spawn_q       <= 1'b0;
         score_pulse_q <= 1'b0;
         score_q       <= 8'd0;
      end else begin
         state_q       <= state_d;
         valid_q       <= valid_d;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            x_q[k]   <= x_d[k];
            gap_q[k] <= gap_d[k];
         end
         cnt_q         <= cnt_d;
         spawn_q       <= spawn_d;
         score_pulse_q <= score_pulse_d;
         score_q       <= score_d;
      end
   end

   generate
      for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
         assign o_Pipe_X[10*g +: 10] = x_q[g];
         assign o_Gap_Y[9*g +: 9]    = gap_q[g];
      end
   endgenerate

   assign o_Pipe_Valid  = valid_q;
   assign o_Spawn       = spawn_q;
   assign o_Score_Pulse = score_pulse_q;
   assign o_Score       = score_q;
   assign o_State       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_spawner.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_spawner
// Summary  : Self-checking bench for pipe_spawner: a behavioural game model
//            compared every cycle, plus hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_spawner;

   localparam int SCREEN_W       = 640;
   localparam int SPAWN_INTERVAL = 90;
   localparam int SPEED          = 2;
   localparam int GAP_MIN        = 80;
   localparam int GAP_STEP       = 8;
   localparam int BIRD_X         = 160;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        tick      = 1'b0;
   logic        start     = 1'b0;
   logic        game_over = 1'b0;
   logic [4:0]  lfsr      = 5'd0;

   logic [2:0]  o_Pipe_Valid;
   logic [29:0] o_Pipe_X;
   logic [26:0] o_Gap_Y;
   logic        o_Spawn;
   logic        o_Score_Pulse;
   logic [7:0]  o_Score;
   logic [1:0]  o_State;

   int checks = 0;
   int errors = 0;

   pipe_spawner #(
      .SCREEN_W      (SCREEN_W),
      .SPAWN_INTERVAL(SPAWN_INTERVAL),
      .SPEED         (SPEED),
      .GAP_MIN       (GAP_MIN),
      .GAP_STEP      (GAP_STEP),
      .BIRD_X        (BIRD_X)
   ) dut (
      .i_Clk        (clk),
      .i_Reset_n    (rst_n),
      .i_Frame_Tick (tick),
      .i_Start      (start),
      .i_Game_Over  (game_over),
      .i_LFSR_Data  (lfsr),
      .o_Pipe_Valid (o_Pipe_Valid),
      .o_Pipe_X     (o_Pipe_X),
      .o_Gap_Y      (o_Gap_Y),
      .o_Spawn      (o_Spawn),
      .o_Score_Pulse(o_Score_Pulse),
      .o_Score      (o_Score),
      .o_State      (o_State)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   int m_state;          // 0 idle, 1 run, 2 frozen
   bit m_valid [3];
   int m_x     [3];
   int m_gap   [3];
   int m_cnt;            // ticks remaining before the next spawn tick
   bit m_spawn;
   bit m_pulse;
   int m_score;

   task automatic m_reset();
      m_state = 0;
      for (int k = 0; k < 3; k++) begin
         m_valid[k] = 0; m_x[k] = 0; m_gap[k] = 0;
      end
      m_cnt = SPAWN_INTERVAL - 1;
      m_spawn = 0; m_pulse = 0; m_score = 0;
   endtask

   task automatic m_step();
      int free_slot;
      int crossed;
      m_spawn = 0;
      m_pulse = 0;
      if (start) begin
         m_state = 1;
         for (int k = 0; k < 3; k++) begin
            m_valid[k] = 0; m_x[k] = 0; m_gap[k] = 0;
         end
         m_cnt = SPAWN_INTERVAL - 1;
         m_score = 0;
      end else if (m_state == 1 && game_over) begin
         m_state = 2;
      end else if (m_state == 1 && tick) begin
         free_slot = -1;
         for (int k = 2; k >= 0; k--) if (!m_valid[k]) free_slot = k;
         crossed = 0;
         for (int k = 0; k < 3; k++) begin
            if (m_valid[k]) begin
               if (m_x[k] < SPEED) m_valid[k] = 0;
               else begin
                  if (m_x[k] >= BIRD_X && m_x[k] - SPEED < BIRD_X) crossed++;
                  m_x[k] = m_x[k] - SPEED;
               end
            end
         end
         if (m_cnt == 0) begin
            m_cnt = SPAWN_INTERVAL - 1;
            if (free_slot >= 0) begin
               m_valid[free_slot] = 1;
               m_x[free_slot]     = SCREEN_W;
               m_gap[free_slot]   = (GAP_MIN + int'(lfsr) * GAP_STEP) % 512;
               m_spawn            = 1;
            end
         end else begin
            m_cnt = m_cnt - 1;
         end
         if (crossed > 0) begin
            m_pulse = 1;
            m_score = (m_score + crossed > 255) ? 255 : m_score + crossed;
         end
      end
   endtask

   // Model advances on the same edges as the design
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_reset();
      else        m_step();
   end

   // Compare every output against the model on each falling edge
   always @(negedge clk) begin
      logic [2:0]  e_valid;
      logic [29:0] e_x;
      logic [26:0] e_gap;
      for (int k = 0; k < 3; k++) begin
         e_valid[k]        = m_valid[k];
         e_x[10*k +: 10]   = 10'(m_x[k]);
         e_gap[9*k +: 9]   = 9'(m_gap[k]);
      end
      check("state", 32'(o_State), 32'(m_state));
      check("valid", 32'(o_Pipe_Valid), 32'(e_valid));
      check("pipe_x", 32'(o_Pipe_X), 32'(e_x));
      check("gap_y", 32'(o_Gap_Y), 32'(e_gap));
      check("spawn", 32'(o_Spawn), 32'(m_spawn));
`ifdef PIPE_SCORE_EN
      check("score_pulse", 32'(o_Score_Pulse), 32'(m_pulse));
      check("score", 32'(o_Score), 32'(m_score));
`else
      check("score_pulse", 32'(o_Score_Pulse), 32'd0);
      check("score", 32'(o_Score), 32'd0);
`endif
   end

   // ------------------------------------------------------------ stimulus
   // Called at a falling edge; returns at the falling edge where the tick's
   // registered result is visible.
   task automatic do_tick(input logic [4:0] v, input int idle);
      repeat (idle) @(negedge clk);
      tick = 1'b1;
      lfsr = v;
      @(negedge clk);
      tick = 1'b0;
      lfsr = 5'($urandom);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int exp_score;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state", 32'(o_State), 32'd0);
      check("rst_valid", 32'(o_Pipe_Valid), 32'd0);
      check("rst_x", 32'(o_Pipe_X), 32'd0);
      check("rst_spawn", 32'(o_Spawn), 32'd0);
      check("rst_score", 32'(o_Score), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Ticks in IDLE do nothing
      do_tick(5'd3, 1);
      check("idle_hold", 32'(o_State), 32'd0);

      pulse_start();
      check("run_state", 32'(o_State), 32'd1);

      // Phase A: first spawn after the 90th tick, then long run
      for (int t = 1; t <= 460; t++) begin
         do_tick((t <= 90) ? 5'd5 : 5'(t % 32), t % 3);
         case (t)
            89: check("no_spawn_89", 32'(o_Spawn), 32'd0);
            90: begin
               check("spawn_90", 32'(o_Spawn), 32'd1);
               check("valid_90", 32'(o_Pipe_Valid), 32'b001);
               check("x0_90", 32'(o_Pipe_X[9:0]), 32'd640);
               check("gap0_90", 32'(o_Gap_Y[8:0]), 32'd120);
            end
            330: check("x0_330", 32'(o_Pipe_X[9:0]), 32'd160);
            331: begin
               check("x0_331", 32'(o_Pipe_X[9:0]), 32'd158);
`ifdef PIPE_SCORE_EN
               check("pulse_331", 32'(o_Score_Pulse), 32'd1);
               check("score_331", 32'(o_Score), 32'd1);
`else
               check("pulse_331", 32'(o_Score_Pulse), 32'd0);
               check("score_331", 32'(o_Score), 32'd0);
`endif
            end
            360: begin
               check("drop_spawn_360", 32'(o_Spawn), 32'd0);
               check("drop_valid_360", 32'(o_Pipe_Valid), 32'b111);
            end
            409: check("x0_409", 32'(o_Pipe_X[9:0]), 32'd2);
            410: begin
               check("x0_410", 32'(o_Pipe_X[9:0]), 32'd0);
               check("valid_410", 32'(o_Pipe_Valid), 32'b111);
            end
            411: begin
               check("retire_valid_411", 32'(o_Pipe_Valid), 32'b110);
               check("retire_x0_411", 32'(o_Pipe_X[9:0]), 32'd0);
            end
            449: check("no_spawn_449", 32'(o_Spawn), 32'd0);
            450: begin
               check("respawn_450", 32'(o_Spawn), 32'd1);
               check("valid_450", 32'(o_Pipe_Valid), 32'b111);
               check("gap0_450", 32'(o_Gap_Y[8:0]), 32'd96);
            end
            default: ;
         endcase
      end
`ifdef PIPE_SCORE_EN
      exp_score = 2;
`else
      exp_score = 0;
`endif
      check("score_460", 32'(o_Score), 32'(exp_score));

      // Phase B: asynchronous reset between clock edges mid-RUN
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_state", 32'(o_State), 32'd0);
      check("async_valid", 32'(o_Pipe_Valid), 32'd0);
      check("async_x", 32'(o_Pipe_X), 32'd0);
      check("async_score", 32'(o_Score), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 3; t++) do_tick(5'd7, 1);
      check("post_rst_idle", 32'(o_State), 32'd0);
      check("post_rst_valid", 32'(o_Pipe_Valid), 32'd0);

      // Phase C: fresh game, maximum LFSR value
      pulse_start();
      for (int t = 1; t <= 92; t++) begin
         do_tick(5'd31, t % 2);
         if (t == 90) check("gap0_max", 32'(o_Gap_Y[8:0]), 32'd328);
      end
      check("x0_c", 32'(o_Pipe_X[9:0]), 32'd636);

      // Phase D: game over coincident with a tick freezes without moving
      @(negedge clk);
      tick = 1'b1; game_over = 1'b1;
      @(negedge clk);
      tick = 1'b0; game_over = 1'b0;
      check("frozen_state", 32'(o_State), 32'd2);
      check("frozen_x0", 32'(o_Pipe_X[9:0]), 32'd636);
      for (int t = 0; t < 3; t++) do_tick(5'd1, 1);
      check("frozen_hold_x0", 32'(o_Pipe_X[9:0]), 32'd636);
      check("frozen_hold_valid", 32'(o_Pipe_Valid), 32'b001);
      pulse_start();
      check("restart_state", 32'(o_State), 32'd1);
      check("restart_valid", 32'(o_Pipe_Valid), 32'd0);
      check("restart_score", 32'(o_Score), 32'd0);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
